// File: rtl/relu_quant_pool.sv
// relu_quant_pool: ReLU + shift/saturate quantiser followed by 2x2 max pooling
// over a raster-ordered convolution output stream.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   pixel_in        signed 32-bit convolution result, raster order
//   pixel_in_valid  pixel_in carries a sample this cycle
//   pixel_out       unsigned 8-bit pooled pixel (holds when not valid)
//   pixel_out_valid single-cycle pulse per pooled pixel
//   frame_done      pulses with the last pooled pixel of a frame
module relu_quant_pool #(
  parameter int unsigned IMG_WIDTH  = 4,
  parameter int unsigned IMG_HEIGHT = 4,
  parameter int unsigned SHIFT      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pixel_in,
  input  logic        pixel_in_valid,
  output logic [7:0]  pixel_out,
  output logic        pixel_out_valid,
  output logic        frame_done
);

  localparam int unsigned DW       = 32;
  localparam int unsigned PW       = 8;
  localparam int unsigned CW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned LB_DEPTH = IMG_WIDTH / 2;
  localparam int unsigned LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  // Stage 1: ReLU, shift and saturate to 8 bits
  logic [DW-1:0] shifted;
  logic [PW-1:0] quant_c;

  always_comb begin
    shifted = pixel_in >> SHIFT;
    if (pixel_in[DW-1]) begin
      quant_c = '0;
    end else if (shifted > DW'(255)) begin
      quant_c = '1;
    end else begin
      quant_c = shifted[PW-1:0];
    end
  end

  logic [PW-1:0] s1_q;
  logic          s1_valid;

  // Stage-1 register; valid follows the input strobe, data only loads on valid
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= pixel_in_valid;
      if (pixel_in_valid) begin
        s1_q <= quant_c;
      end
    end
  end

  // Stage 2: horizontal pair max, line buffer for the even row, vertical max
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [PW-1:0]  pair;
  logic [PW-1:0]  line_buf [LB_DEPTH];
  logic [LBW-1:0] lb_idx;
  logic [PW-1:0]  lb_rd;
  logic [PW-1:0]  hmax;
  logic [PW-1:0]  vmax;
  logic           col_last;
  logic           row_last;

  always_comb begin
    col_last = (col == CW'(IMG_WIDTH - 1));
    row_last = (row == RW'(IMG_HEIGHT - 1));
    lb_idx   = LBW'(col >> 1);
    lb_rd    = line_buf[lb_idx];
    hmax     = (pair > s1_q) ? pair : s1_q;
    vmax     = (lb_rd > hmax) ? lb_rd : hmax;
  end

  // Even-row horizontal maxima wait here for the matching odd row
  always_ff @(posedge clock) begin
    if (s1_valid && col[0] && !row[0]) begin
      line_buf[lb_idx] <= hmax;
    end
  end

  // Counters, pair register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      col             <= '0;
      row             <= '0;
      pair            <= '0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      pixel_out_valid <= 1'b0;
      frame_done      <= 1'b0;
      if (s1_valid) begin
        if (!col[0]) begin
          pair <= s1_q;
        end else if (row[0]) begin
          pixel_out       <= vmax;
          pixel_out_valid <= 1'b1;
          frame_done      <= row_last && col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_quant_pool.sv
// Self-checking bench for relu_quant_pool (IMG_WIDTH=4, IMG_HEIGHT=4, SHIFT=4).
// A frame-level model pools 2x2 windows of quantised samples and schedules
// each expected output two cycles after the odd/odd input; a compare process
// checks the outputs every cycle. Directed frames also pin literal results.
module tb_relu_quant_pool;

  localparam int W = 4;
  localparam int H = 4;
  localparam int S = 4;

  logic        clock;
  logic        reset;
  logic [31:0] pixel_in;
  logic        pixel_in_valid;
  logic [7:0]  pixel_out;
  logic        pixel_out_valid;
  logic        frame_done;

  relu_quant_pool #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(S)) dut (
    .clock          (clock),
    .reset          (reset),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .frame_done     (frame_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int at_edge;
    int val;
    bit done;
  } exp_t;

  int   cyc = 0;
  bit   rst_at_edge = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t expq[$];
  int   qv[H][W];
  int   mr = 0;
  int   mc = 0;
  int   cap_val[$];
  bit   cap_done[$];
  int   exp_last = 0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    rst_at_edge = reset;
  end

  function automatic void chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endfunction

  // ReLU, floor-divide by 2^S, clamp to 255
  function automatic int quant(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    if (v < 0) return 0;
    v = v / (longint'(1) << S);
    return (v > 255) ? 255 : int'(v);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Sample driven now is captured at edge cyc+1; pooled result visible after cyc+2
  task automatic model_push(input logic [31:0] x);
    exp_t e;
    qv[mr][mc] = quant(x);
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      e.at_edge = cyc + 2;
      e.val  = max4(qv[mr-1][mc-1], qv[mr-1][mc], qv[mr][mc-1], qv[mr][mc]);
      e.done = (mr == H - 1) && (mc == W - 1);
      expq.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  // Compare process: one output check set per cycle, just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (pixel_out_valid) begin
        cap_val.push_back(int'(pixel_out));
        cap_done.push_back(frame_done);
      end
      while (expq.size() > 0 && expq[0].at_edge < cyc) begin
        e = expq.pop_front();
        chk("missed_output", 0, 1);
      end
      if (rst_at_edge) begin
        chk("reset_valid", int'(pixel_out_valid), 0);
        chk("reset_done", int'(frame_done), 0);
        chk("reset_out", int'(pixel_out), 0);
        exp_last = 0;
      end else if (expq.size() > 0 && expq[0].at_edge == cyc) begin
        e = expq.pop_front();
        chk("out_valid", int'(pixel_out_valid), 1);
        chk("out_value", int'(pixel_out), e.val);
        chk("frame_done", int'(frame_done), int'(e.done));
        exp_last = e.val;
      end else begin
        chk("idle_valid", int'(pixel_out_valid), 0);
        chk("idle_done", int'(frame_done), 0);
        chk("hold_out", int'(pixel_out), exp_last);
      end
    end
  end

  task automatic drive(input logic [31:0] x, input bit v);
    @(negedge clock);
    pixel_in = x;
    pixel_in_valid = v;
    if (v) model_push(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive($urandom, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b1;
      pixel_in = $urandom;
      pixel_in_valid = 1'($urandom_range(0, 1));
      expq.delete();
      mr = 0;
      mc = 0;
    end
    @(negedge clock);
    reset = 1'b0;
    pixel_in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] v[W*H], input int gap);
    for (int i = 0; i < W * H; i++) begin
      drive(v[i], 1'b1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_caps(input string name, input int ev[4]);
    chk({name, "_count"}, cap_val.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_val.size()) begin
        chk({name, "_value"}, cap_val[i], ev[i]);
        chk({name, "_done"}, int'(cap_done[i]), (i == 3) ? 1 : 0);
      end
    end
    cap_val.delete();
    cap_done.delete();
  endtask

  function automatic logic [31:0] rand_sample();
    logic [31:0] b[6];
    b[0] = 32'h0000_0FF0; b[1] = 32'h0000_0FFF; b[2] = 32'h0000_0FEF;
    b[3] = 32'h0000_1000; b[4] = 32'h7FFF_FFFF; b[5] = 32'h8000_0000;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 32'h1FFF));
      2: return -32'($urandom_range(1, 1000));
      default: return b[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    logic [31:0] fv[W*H];
    int ev[4];
    reset = 1'b1;
    pixel_in = '0;
    pixel_in_valid = 1'b0;

    // Reset held with random inputs
    do_reset(3);
    idle(2);

    // Dense constant frame
    cap_val.delete(); cap_done.delete();
    for (int i = 0; i < 16; i++) fv[i] = 32'h100;
    send_frame(fv, 0);
    idle(4);
    ev = '{16, 16, 16, 16};
    check_caps("dense_0x100", ev);

    // Negative samples clamp to zero
    for (int i = 0; i < 16; i++) fv[i] = 32'hFFFF_FFF0;
    fv[0] = -32'sd5; fv[1] = -32'sd1; fv[4] = 32'h30; fv[5] = -32'sh7FFF_FFFF;
    send_frame(fv, 0);
    idle(4);
    ev = '{3, 0, 0, 0};
    check_caps("relu_window", ev);

    // Large positive saturates
    for (int i = 0; i < 16; i++) fv[i] = 32'h0;
    fv[0] = 32'h0001_0000;
    send_frame(fv, 0);
    idle(4);
    ev = '{255, 0, 0, 0};
    check_caps("saturate", ev);

    // Ramp with gaps
    for (int i = 0; i < 16; i++) fv[i] = 32'(i << 4);
    send_frame(fv, 1);
    idle(4);
    ev = '{5, 7, 13, 15};
    check_caps("ramp_gaps", ev);

    // Saturation boundaries
    for (int i = 0; i < 16; i++) fv[i] = 32'h0;
    fv[0] = 32'h0FEF; fv[2] = 32'h0FFF; fv[8] = 32'h000F; fv[10] = 32'h001F;
    send_frame(fv, 0);
    idle(4);
    ev = '{254, 255, 0, 1};
    check_caps("boundary", ev);

    // Mid-frame reset discards the partial frame
    for (int i = 0; i < 6; i++) drive(32'hFF0, 1'b1);
    do_reset(1);
    for (int i = 0; i < 16; i++) fv[i] = 32'h20;
    send_frame(fv, 0);
    idle(4);
    ev = '{2, 2, 2, 2};
    check_caps("reset_abort", ev);

    // Random back-to-back frames with random gaps, one random mid-frame reset
    for (int f = 0; f < 8; f++) begin
      if (f == 5) begin
        for (int i = 0; i < 7; i++) drive(rand_sample(), 1'b1);
        do_reset(2);
      end
      for (int i = 0; i < W * H; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive(rand_sample(), 1'b1);
      end
    end
    idle(6);
    chk("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
